// File: rtl/phy_reg_free_list.sv
// Physical register free list: a circular FIFO of free pregs, allocated by rename
// and refilled by commit, with a committed head used to roll back on flush.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 2
`endif
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 2
`endif

module phy_reg_free_list #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  localparam int DW       = `DECODE_WIDTH,
  localparam int CW       = `COMMIT_WIDTH,
  localparam int FL_DEPTH = PHY_REG_NUM - ARCH_REG_NUM,
  localparam int PW       = $clog2(PHY_REG_NUM),
  localparam int FW       = $clog2(FL_DEPTH),
  localparam int PTRW     = FW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid_i,
  input  logic [DW-1:0]          alloc_req_i,
  output logic                   alloc_ready_o,
  output logic [DW-1:0][PW-1:0]  preg_o,
  input  logic [CW-1:0]          commit_i,
  input  logic [CW-1:0][PW-1:0]  commit_ppdst_i,
  input  logic                   restore_i,
  output logic [PTRW-1:0]        free_cnt_o
);

  logic [PW-1:0]   fifo [FL_DEPTH];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] arch_head;
  logic [PTRW-1:0] tail;

  logic [PTRW-1:0] alloc_cnt;
  logic [PTRW-1:0] commit_cnt;
  logic [FW-1:0]   alloc_idx;
  logic [FW-1:0]   commit_idx [CW];
  logic            alloc_fire;

  // Count comes from registered pointers only, so pregs released this cycle
  // are not visible to allocation until the next one.
  assign free_cnt_o = tail - head;

  always_comb begin
    alloc_cnt = '0;
    alloc_idx = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      alloc_idx = head[FW-1:0] + alloc_cnt[FW-1:0];
      preg_o[i] = alloc_req_i[i] ? fifo[alloc_idx] : '0;
      alloc_cnt = alloc_cnt + PTRW'(alloc_req_i[i]);
    end
  end

  always_comb begin
    commit_cnt = '0;
    for (int unsigned k = 0; k < CW; k++) begin
      commit_idx[k] = tail[FW-1:0] + commit_cnt[FW-1:0];
      commit_cnt    = commit_cnt + PTRW'(commit_i[k]);
    end
  end

  assign alloc_ready_o = !restore_i && (free_cnt_o >= alloc_cnt);
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      arch_head <= '0;
      tail      <= PTRW'(FL_DEPTH);
      for (int unsigned k = 0; k < FL_DEPTH; k++) begin
        fifo[k] <= PW'(ARCH_REG_NUM + k);
      end
    end else begin
      for (int unsigned k = 0; k < CW; k++) begin
        if (commit_i[k]) fifo[commit_idx[k]] <= commit_ppdst_i[k];
      end
      tail      <= tail + commit_cnt;
      arch_head <= arch_head + commit_cnt;
      // Rollback target includes this cycle's commits so it matches the new arch_head.
      if (restore_i)       head <= arch_head + commit_cnt;
      else if (alloc_fire) head <= head + alloc_cnt;
    end
  end

  free_list_no_overflow: assert property (@(posedge clk) disable iff (rst)
    int'(free_cnt_o) + int'(commit_cnt)
      <= FL_DEPTH + (alloc_fire ? int'(alloc_cnt) : 0));

endmodule

// File: tb/tb_phy_reg_free_list.sv
// Directed and model-checked stimulus for phy_reg_free_list (DW=2, CW=2, 32-entry list).
module tb_phy_reg_free_list;

  logic            clk;
  logic            rst;
  logic            alloc_valid_i;
  logic [1:0]      alloc_req_i;
  logic            alloc_ready_o;
  logic [1:0][5:0] preg_o;
  logic [1:0]      commit_i;
  logic [1:0][5:0] commit_ppdst_i;
  logic            restore_i;
  logic [5:0]      free_cnt_o;

  int checks = 0;
  int failures = 0;

  phy_reg_free_list #(.PHY_REG_NUM(64), .ARCH_REG_NUM(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid_i  (alloc_valid_i),
    .alloc_req_i    (alloc_req_i),
    .alloc_ready_o  (alloc_ready_o),
    .preg_o         (preg_o),
    .commit_i       (commit_i),
    .commit_ppdst_i (commit_ppdst_i),
    .restore_i      (restore_i),
    .free_cnt_o     (free_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid_i  = 1'b0;
    alloc_req_i    = 2'b00;
    commit_i       = 2'b00;
    commit_ppdst_i = '0;
    restore_i      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  int fq[$];
  int outq[$];
  int ncommit;
  int pick;
  int rank;
  int exp_p;
  int pc;
  int cval [2];

  initial begin
    clk = 1'b0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_free_cnt", 32'(free_cnt_o), 32);
    check("rst_ready", 32'(alloc_ready_o), 1);
    check("rst_preg0_noreq", 32'(preg_o[0]), 0);

    // Two-slot group right after reset
    alloc_valid_i = 1'b1; alloc_req_i = 2'b11; #1;
    check("grp_preg0", 32'(preg_o[0]), 32);
    check("grp_preg1", 32'(preg_o[1]), 33);
    check("grp_ready", 32'(alloc_ready_o), 1);
    tick();
    idle_inputs(); #1;
    check("grp_free_cnt", 32'(free_cnt_o), 30);

    // Compacted slot ranking
    do_reset();
    alloc_valid_i = 1'b1; alloc_req_i = 2'b10; #1;
    check("rank_preg1", 32'(preg_o[1]), 32);
    check("rank_preg0_zero", 32'(preg_o[0]), 0);
    tick();
    alloc_req_i = 2'b01; #1;
    check("rank_next_preg0", 32'(preg_o[0]), 33);
    tick();
    idle_inputs(); #1;
    check("rank_free_cnt", 32'(free_cnt_o), 30);

    // Exhaust, stall, and same-cycle release not visible
    do_reset();
    alloc_valid_i = 1'b1; alloc_req_i = 2'b11;
    repeat (16) tick();
    idle_inputs(); #1;
    check("empty_free_cnt", 32'(free_cnt_o), 0);
    alloc_valid_i = 1'b1; alloc_req_i = 2'b01;
    commit_i = 2'b01; commit_ppdst_i[0] = 6'd5; #1;
    check("empty_ready_stall", 32'(alloc_ready_o), 0);
    tick();
    commit_i = 2'b00; commit_ppdst_i = '0; #1;
    check("release_free_cnt", 32'(free_cnt_o), 1);
    check("release_ready", 32'(alloc_ready_o), 1);
    check("release_preg0", 32'(preg_o[0]), 5);
    tick();
    idle_inputs(); #1;
    check("release_alloc_free_cnt", 32'(free_cnt_o), 0);

    // Restore with a same-cycle commit
    do_reset();
    alloc_valid_i = 1'b1; alloc_req_i = 2'b11;
    tick();
    tick();
    commit_i = 2'b01; commit_ppdst_i[0] = 6'd7; restore_i = 1'b1; #1;
    check("restore_ready_low", 32'(alloc_ready_o), 0);
    check("restore_pre_free_cnt", 32'(free_cnt_o), 28);
    tick();
    idle_inputs(); #1;
    check("restore_free_cnt", 32'(free_cnt_o), 32);
    alloc_valid_i = 1'b1; alloc_req_i = 2'b11; #1;
    check("restore_preg0", 32'(preg_o[0]), 33);
    check("restore_preg1", 32'(preg_o[1]), 34);
    tick();
    idle_inputs(); #1;
    check("restore_alloc_free_cnt", 32'(free_cnt_o), 30);

    // Reset during a stalled allocation
    do_reset();
    alloc_valid_i = 1'b1; alloc_req_i = 2'b11;
    repeat (16) tick();
    alloc_req_i = 2'b01; #1;
    check("stall_ready_low", 32'(alloc_ready_o), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rst_stall_free_cnt", 32'(free_cnt_o), 32);
    check("rst_stall_ready", 32'(alloc_ready_o), 1);
    check("rst_stall_preg0", 32'(preg_o[0]), 32);
    idle_inputs();

    // Random legal traffic against a queue model
    do_reset();
    fq.delete();
    outq.delete();
    for (int k = 0; k < 32; k++) fq.push_back(32 + k);
    for (int cyc = 0; cyc < 120; cyc++) begin
      alloc_req_i   = 2'($urandom_range(0, 3));
      alloc_valid_i = 1'($urandom_range(0, 1));
      ncommit = $urandom_range(0, (outq.size() < 2) ? outq.size() : 2);
      commit_i = 2'b00;
      commit_ppdst_i = '0;
      if (ncommit == 2) commit_i = 2'b11;
      else if (ncommit == 1) commit_i = 2'($urandom_range(1, 2));
      for (int s = 0; s < 2; s++) begin
        if (commit_i[s]) begin
          pick = $urandom_range(0, outq.size() - 1);
          cval[s] = outq[pick];
          outq.delete(pick);
          commit_ppdst_i[s] = 6'(cval[s]);
        end
      end
      #1;
      pc = int'(alloc_req_i[0]) + int'(alloc_req_i[1]);
      check("rnd_free_cnt", 32'(free_cnt_o), 32'(fq.size()));
      check("rnd_ready", 32'(alloc_ready_o), (fq.size() >= pc) ? 32'd1 : 32'd0);
      rank = 0;
      for (int s = 0; s < 2; s++) begin
        if (alloc_req_i[s]) begin
          exp_p = (rank < fq.size()) ? fq[rank] : -1;
          rank++;
          if (exp_p >= 0) check("rnd_preg", 32'(preg_o[s]), 32'(exp_p));
        end else begin
          check("rnd_preg_zero", 32'(preg_o[s]), 0);
        end
      end
      if (alloc_valid_i && fq.size() >= pc) begin
        for (int s = 0; s < pc; s++) outq.push_back(fq.pop_front());
      end
      for (int s = 0; s < 2; s++) begin
        if (commit_i[s]) fq.push_back(cval[s]);
      end
      tick();
    end
    idle_inputs(); #1;
    check("rnd_final_free_cnt", 32'(free_cnt_o), 32'(fq.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
